hpdcache_sram_wmask_ctrl: RTL

HPDCACHE_SRAM_WMASK_CTRL -- requirements
Module: hpdcache_sram_wmask_ctrl

---
 rtl/hpdcache_sram_ctrl_pkg.sv | 10 +
 rtl/hpdcache_fifo_reg.sv | 57 +++++
 rtl/hpdcache_sram_wmask_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/hpdcache_sram_ctrl_pkg.sv
// rtl/hpdcache_sram_ctrl_pkg.sv - shared controller state type
// Contents: ctrl_state_e, the state type of the SRAM wmask controller FSM.
package hpdcache_sram_ctrl_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// rtl/hpdcache_fifo_reg.sv - small register-based FIFO
// Ports: clk_i/rst_ni clock and sync active-low reset; w_i/wdata_i push;
//        r_i pop (only while rok_o); rok_o/rdata_o head entry; count_o occupancy.
module hpdcache_fifo_reg #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned WIDTH      = 32,
   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             w_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             r_i,
   output logic             rok_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] cnt;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (w_i) begin
         mem[wptr] <= wdata_i;
      end
   end

   // A push into a full FIFO is only legal together with a pop: the read
   // pointer moves off the head entry in the same cycle the slot is reused.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (w_i) begin
            wptr <= ptr_next(wptr);
         end
         if (r_i) begin
            rptr <= ptr_next(rptr);
         end
         cnt <= cnt + CNT_W'(w_i) - CNT_W'(r_i);
      end
   end

   assign rok_o   = (cnt != '0);
   assign rdata_o = mem[rptr];
   assign count_o = cnt;

endmodule

// File: rtl/hpdcache_sram_wmask_ctrl.sv
// rtl/hpdcache_sram_wmask_ctrl.sv - request/response front end for a 1RW masked SRAM
// Ports: clk/rst_n clock and sync active-low reset; req_* request handshake
//        and payload; rsp_* read-response handshake; init_done_o set once the
//        array has been cleared; sram_* drive the SRAM macro.
module hpdcache_sram_wmask_ctrl
   import hpdcache_sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 6,
   parameter int unsigned DATA_SIZE = 64,
   parameter int unsigned DEPTH     = 2**ADDR_SIZE,
   parameter int unsigned NDATA     = 1,
   parameter bit          INIT_EN   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid_i,
   output logic                         req_ready_o,
   input  logic                         req_we_i,
   input  logic [ADDR_SIZE-1:0]         req_addr_i,
   input  logic [NDATA*DATA_SIZE-1:0]   req_wdata_i,
   input  logic [NDATA*DATA_SIZE-1:0]   req_wmask_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [NDATA*DATA_SIZE-1:0]   rsp_rdata_o,
   output logic                         init_done_o,
   output logic                         sram_cs_o,
   output logic                         sram_we_o,
   output logic [ADDR_SIZE-1:0]         sram_addr_o,
   output logic [NDATA*DATA_SIZE-1:0]   sram_wdata_o,
   output logic [NDATA*DATA_SIZE-1:0]   sram_wmask_o,
   input  logic [NDATA*DATA_SIZE-1:0]   sram_rdata_i
);

   ctrl_state_e          state;
   logic [ADDR_SIZE-1:0] init_cnt;
   logic                 init_done_q;
   logic                 rd_inflight;
   logic [1:0]           fifo_count;
   logic [2:0]           occupancy;
   logic                 pop;
   logic                 credit;
   logic                 accept;

   // A read owns a FIFO slot from acceptance until it is popped, so the
   // in-flight read counts against the two slots; a pop this cycle frees one.
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign occupancy   = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, pop};
   assign credit      = (occupancy < 3'd2);
   // rst_n gating keeps the SRAM idle from the very first reset cycle.
   assign req_ready_o = rst_n & init_done_q & credit;
   assign accept      = req_valid_i & req_ready_o;
   assign init_done_o = init_done_q;

   always_comb begin
      if (state == ST_INIT) begin
         sram_cs_o    = rst_n;
         sram_we_o    = 1'b1;
         sram_addr_o  = init_cnt;
         sram_wdata_o = '0;
         sram_wmask_o = '1;
      end else begin
         sram_cs_o    = accept;
         sram_we_o    = req_we_i;
         sram_addr_o  = req_addr_i;
         sram_wdata_o = req_wdata_i;
         sram_wmask_o = req_wmask_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= INIT_EN ? ST_INIT : ST_READY;
         init_cnt    <= '0;
         init_done_q <= 1'b0;
         rd_inflight <= 1'b0;
      end else begin
         rd_inflight <= accept & ~req_we_i;
         if (state == ST_INIT) begin
            if (init_cnt == ADDR_SIZE'(DEPTH - 1)) begin
               state       <= ST_READY;
               init_done_q <= 1'b1;
            end else begin
               init_cnt <= init_cnt + ADDR_SIZE'(1);
            end
         end else begin
            init_done_q <= 1'b1;
         end
      end
   end

   // Read data is valid exactly one cycle after the strobe, which is the
   // cycle rd_inflight is high, so it is captured straight from the macro.
   hpdcache_fifo_reg #(
      .FIFO_DEPTH (2),
      .WIDTH      (NDATA*DATA_SIZE)
   ) i_rsp_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .w_i     (rd_inflight),
      .wdata_i (sram_rdata_i),
      .r_i     (pop),
      .rok_o   (rsp_valid_o),
      .rdata_o (rsp_rdata_o),
      .count_o (fifo_count)
   );

endmodule
